i2c_codec_responder: RTL and testbench

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

---
 rtl/i2c_codec_responder_pkg.sv | 35 +++
 rtl/i2c_codec_responder_if.sv | 11 +
 rtl/i2c_line_sync.sv | 46 ++++
 rtl/i2c_codec_responder.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_codec_responder_pkg.sv
// Shared audio-codec definitions: responder FSM states, default bus address
// and the register indices of the codec control map.
package i2c_codec_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE_HI,
    ST_ACK_HI,
    ST_BYTE_LO,
    ST_ACK_LO,
    ST_IGNORE
  } state_t;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;

  localparam logic [3:0] REG_LEFT_IN  = 4'h0;
  localparam logic [3:0] REG_RIGHT_IN = 4'h1;
  localparam logic [3:0] REG_LEFT_HP  = 4'h2;
  localparam logic [3:0] REG_RIGHT_HP = 4'h3;
  localparam logic [3:0] REG_ANALOG   = 4'h4;
  localparam logic [3:0] REG_DIGITAL  = 4'h5;
  localparam logic [3:0] REG_POWER    = 4'h6;
  localparam logic [3:0] REG_FORMAT   = 4'h7;
  localparam logic [3:0] REG_SAMPLING = 4'h8;
  localparam logic [3:0] REG_ACTIVE   = 4'h9;
  localparam logic [3:0] REG_RESET    = 4'hF;

  // Address byte an initiator sends to write to a device at address a.
  function automatic logic [7:0] wr_addr_byte(input logic [6:0] a);
    return {a, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Two-wire bus bundle: clock, resolved data line and the responder's pull-down.
// Valid/ready does not apply here; SDA may change only while SCL is low,
// except for START/STOP, and the responder only pulls SDA during ACK slots.
interface i2c_codec_responder_if;
  logic scl;
  logic sda;
  logic sda_oen;

  modport master (output scl, output sda, input sda_oen);
  modport slave  (input scl, input sda, output sda_oen);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL and SDA into the i_clk domain and flags SCL edges and
// START/STOP conditions from the synchronised value and its previous sample.
module i2c_line_sync (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  i2c_codec_responder_if.slave   bus,
  output logic                   o_sda,
  output logic                   o_scl_rise,
  output logic                   o_scl_fall,
  output logic                   o_start,
  output logic                   o_stop
);

  logic [1:0] r_scl_ff;
  logic [1:0] r_sda_ff;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic [2:0] r_primed;
  logic       w_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_ff   <= 2'b11;
      r_sda_ff   <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_primed   <= 3'b000;
    end else begin
      r_scl_ff   <= {r_scl_ff[0], bus.scl};
      r_sda_ff   <= {r_sda_ff[0], bus.sda};
      r_scl_prev <= r_scl_ff[1];
      r_sda_prev <= r_sda_ff[1];
      r_primed   <= {r_primed[1:0], 1'b1};
    end
  end

  // The reset value "bus idle" may disagree with the real lines; hold off
  // edge reporting until every stage carries a genuine sample.
  assign w_ok       = r_primed[2];
  assign o_sda      = r_sda_ff[1];
  assign o_scl_rise = w_ok &  r_scl_ff[1] & ~r_scl_prev;
  assign o_scl_fall = w_ok & ~r_scl_ff[1] &  r_scl_prev;
  assign o_start    = w_ok & r_scl_ff[1] & r_scl_prev & r_sda_prev & ~r_sda_ff[1];
  assign o_stop     = w_ok & r_scl_ff[1] & r_scl_prev & ~r_sda_prev & r_sda_ff[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C responder for an audio codec: accepts two-byte register words
// (7-bit address, 9-bit data) and stores them in a small register file.
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int         NUM_REGS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic [7:0] o_wr_count
);

  i2c_codec_responder_if w_bus ();

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic       r_byte_done;
  logic       w_byte_done_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [7:0] r_hi;
  logic [7:0] w_hi_nxt;
  logic       r_sda_oen;
  logic       w_sda_oen_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       w_wr_en;

  logic       r_reg_wr;
  logic [6:0] r_reg_addr;
  logic [8:0] r_reg_data;
  logic [7:0] r_wr_count;
  logic [3:0] w_wr_idx;
  logic [8:0] w_wr_data;
  logic [8:0] w_regs [16];

  assign w_bus.scl     = i_scl;
  assign w_bus.sda     = i_sda;
  assign w_bus.sda_oen = r_sda_oen;

  i2c_line_sync u_line_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .bus        (w_bus),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus conditions take priority over whatever byte or ACK slot is in flight.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_done_nxt = r_byte_done;
    w_shift_nxt     = r_shift;
    w_hi_nxt        = r_hi;
    w_sda_oen_nxt   = r_sda_oen;
    w_busy_nxt      = r_busy;
    w_wr_en         = 1'b0;
    if (w_start) begin
      w_state_nxt     = ST_ADDR;
      w_bit_cnt_nxt   = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_sda_oen_nxt   = 1'b0;
      w_busy_nxt      = 1'b1;
    end else if (w_stop) begin
      w_state_nxt     = ST_IDLE;
      w_bit_cnt_nxt   = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_sda_oen_nxt   = 1'b0;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
          if (w_scl_rise && !r_byte_done) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_done_nxt = 1'b1;
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_bit_cnt_nxt   = 3'd0;
            case (r_state)
              ST_ADDR: begin
                if (r_shift == {DEV_ADDR, 1'b0}) begin
                  w_state_nxt   = ST_ADDR_ACK;
                  w_sda_oen_nxt = 1'b1;
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end
              ST_BYTE_HI: begin
                w_hi_nxt      = r_shift;
                w_state_nxt   = ST_ACK_HI;
                w_sda_oen_nxt = 1'b1;
              end
              default: begin
                w_state_nxt   = ST_ACK_LO;
                w_sda_oen_nxt = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_ACK_HI, ST_ACK_LO: begin
          if (w_scl_fall) begin
            w_sda_oen_nxt = 1'b0;
            case (r_state)
              ST_ADDR_ACK: w_state_nxt = ST_BYTE_HI;
              ST_ACK_HI:   w_state_nxt = ST_BYTE_LO;
              default: begin
                w_state_nxt = ST_IGNORE;
                w_wr_en     = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign w_wr_idx  = r_hi[4:1];
  assign w_wr_data = {r_hi[0], r_shift};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
      r_shift     <= 8'd0;
      r_hi        <= 8'd0;
      r_sda_oen   <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= 7'd0;
      r_reg_data  <= 9'd0;
      r_wr_count  <= 8'd0;
    end else begin
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_shift     <= w_shift_nxt;
      r_hi        <= w_hi_nxt;
      r_sda_oen   <= w_sda_oen_nxt;
      r_busy      <= w_busy_nxt;
      r_reg_wr    <= w_wr_en;
      if (w_wr_en) begin
        r_reg_addr <= r_hi[7:1];
        r_reg_data <= w_wr_data;
        if (r_wr_count != 8'hFF) r_wr_count <= r_wr_count + 8'd1;
      end
    end
  end

  // Rows beyond NUM_REGS read as zero and ignore writes.
  for (genvar g = 0; g < 16; g++) begin : g_reg
    if (g < NUM_REGS) begin : g_row
      logic [8:0] r_row;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_row <= 9'd0;
        end else if (w_wr_en && (w_wr_idx == 4'(g))) begin
          r_row <= w_wr_data;
        end
      end
      assign w_regs[g] = r_row;
    end else begin : g_tie
      assign w_regs[g] = 9'd0;
    end
  end

  assign o_sda_oen  = w_bus.sda_oen;
  assign o_reg_wr   = r_reg_wr;
  assign o_reg_addr = r_reg_addr;
  assign o_reg_data = r_reg_data;
  assign o_rd_data  = w_regs[i_rd_addr];
  assign o_busy     = r_busy;
  assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: an I2C initiator drives directed and random
// write transactions; a transaction-level model predicts ACKs and register writes.
module tb_i2c_codec_responder;

  localparam int Q = 5;

  logic       clk;
  logic       rst_n;
  logic       m_sda;
  logic [3:0] rd_addr;
  logic       o_reg_wr;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;
  logic [8:0] o_rd_data;
  logic       o_busy;
  logic [7:0] o_wr_count;

  int n_pass;
  int n_total;

  logic [15:0] exp_q[$];
  logic [8:0]  m_regs [16];
  int          m_count;
  logic [6:0]  m_last_addr;
  logic [8:0]  m_last_data;
  logic [7:0]  seg_b [8];
  int          seg_n;

  i2c_codec_responder_if bus ();
  assign bus.sda = m_sda & ~bus.sda_oen;

  i2c_codec_responder #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (bus.scl),
    .i_sda      (bus.sda),
    .o_sda_oen  (bus.sda_oen),
    .o_reg_wr   (o_reg_wr),
    .o_reg_addr (o_reg_addr),
    .o_reg_data (o_reg_data),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (o_rd_data),
    .o_busy     (o_busy),
    .o_wr_count (o_wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // model
  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 9'd0;
    m_count     = 0;
    m_last_addr = 7'd0;
    m_last_data = 9'd0;
  endtask

  task automatic model_write(input int hi, input int lo);
    int a;
    int d;
    a = hi / 2;
    d = (hi % 2) * 256 + lo;
    exp_q.push_back({7'(a), 9'(d)});
    m_regs[a % 16] = 9'(d);
    if (m_count < 255) m_count++;
    m_last_addr = 7'(a);
    m_last_data = 9'(d);
  endtask

  // drivers
  task automatic bus_start();
    m_sda = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b0;
    wait_clk(Q);
    chk("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    m_sda = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    chk("oen_data_bit", 32'(bus.sda_oen), 32'd0);
    wait_clk(Q);
    bus.scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic ack_clk(input logic exp_ack);
    m_sda = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(Q);
    chk("ack_slot", 32'(bus.sda_oen), 32'(exp_ack));
    wait_clk(Q);
    bus.scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_clk(exp_ack);
  endtask

  // Sends seg_b[0..seg_n-1] after a START; the model decides ACKs and writes.
  task automatic send_seg();
    logic ok;
    ok = (seg_n > 0) && (seg_b[0] == 8'h34);
    if (ok && seg_n >= 3) model_write(int'(seg_b[1]), int'(seg_b[2]));
    for (int i = 0; i < seg_n; i++) send_byte(seg_b[i], ok && (i < 3));
  endtask

  task automatic check_end(input string nm);
    chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_count"}, 32'(o_wr_count), 32'(m_count));
    chk({nm, "_addr"}, 32'(o_reg_addr), 32'(m_last_addr));
    chk({nm, "_data"}, 32'(o_reg_data), 32'(m_last_data));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk({nm, "_rd"}, 32'(o_rd_data), 32'(m_regs[i]));
    end
  endtask

  // scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && o_reg_wr) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write",
                 o_reg_addr, o_reg_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(o_reg_addr), 32'(e[15:9]));
        chk("wr_data", 32'(o_reg_data), 32'(e[8:0]));
      end
    end
  end

  initial begin
    #800000;
    n_total++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.scl = 1'b1;
    m_sda   = 1'b1;
    rd_addr = 4'd0;
    model_clear();
    wait_clk(5);
    chk("rst_oen", 32'(bus.sda_oen), 32'd0);
    chk("rst_wr", 32'(o_reg_wr), 32'd0);
    chk("rst_addr", 32'(o_reg_addr), 32'd0);
    chk("rst_data", 32'(o_reg_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_count", 32'(o_wr_count), 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // reset register write
    seg_b[0] = 8'h34; seg_b[1] = 8'h1E; seg_b[2] = 8'h00; seg_n = 3;
    bus_start(); send_seg(); bus_stop();
    check_end("t_reset_reg");
    chk("lit_addr_0f", 32'(o_reg_addr), 32'h0F);
    chk("lit_data_000", 32'(o_reg_data), 32'h000);
    chk("lit_count_1", 32'(o_wr_count), 32'd1);

    // analog path write, read back
    seg_b[0] = 8'h34; seg_b[1] = 8'h08; seg_b[2] = 8'h15; seg_n = 3;
    bus_start(); send_seg(); bus_stop();
    check_end("t_analog");
    chk("lit_addr_04", 32'(o_reg_addr), 32'h04);
    chk("lit_data_015", 32'(o_reg_data), 32'h015);
    rd_addr = 4'd4;
    #1;
    chk("lit_rd4_015", 32'(o_rd_data), 32'h015);

    // wrong device address
    seg_b[0] = 8'h36; seg_b[1] = 8'h08; seg_b[2] = 8'h15; seg_n = 3;
    bus_start(); send_seg(); bus_stop();
    check_end("t_wrong_addr");
    chk("lit_count_still_2", 32'(o_wr_count), 32'd2);

    // partial word, STOP
    seg_b[0] = 8'h34; seg_b[1] = 8'h12; seg_n = 2;
    bus_start(); send_seg(); bus_stop();
    check_end("t_partial");
    rd_addr = 4'd9;
    #1;
    chk("lit_rd9_zero", 32'(o_rd_data), 32'h000);

    // partial word, repeated START, full word
    seg_b[0] = 8'h34; seg_b[1] = 8'h12; seg_n = 2;
    bus_start(); send_seg();
    seg_b[2] = 8'h01; seg_n = 3;
    bus_start(); send_seg(); bus_stop();
    check_end("t_rep_start");
    chk("lit_addr_09", 32'(o_reg_addr), 32'h09);
    chk("lit_data_001", 32'(o_reg_data), 32'h001);
    chk("lit_count_3", 32'(o_wr_count), 32'd3);

    // reset in the middle of the low data byte
    bus_start();
    send_byte(8'h34, 1'b1);
    send_byte(8'h08, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(1'b0);
    m_sda = 1'b1;
    wait_clk(Q);
    bus.scl = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    model_clear();
    #1;
    rd_addr = 4'd4;
    #1;
    chk("mid_rst_oen", 32'(bus.sda_oen), 32'd0);
    chk("mid_rst_wr", 32'(o_reg_wr), 32'd0);
    chk("mid_rst_addr", 32'(o_reg_addr), 32'd0);
    chk("mid_rst_data", 32'(o_reg_data), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_count", 32'(o_wr_count), 32'd0);
    chk("mid_rst_rd4", 32'(o_rd_data), 32'd0);
    wait_clk(Q);
    bus.scl = 1'b0;
    wait_clk(Q);
    rst_n = 1'b1;
    for (int i = 2; i >= 0; i--) send_bit(1'b1);
    ack_clk(1'b0);
    bus_stop();
    check_end("t_after_rst");
    seg_b[0] = 8'h34; seg_b[1] = 8'h12; seg_b[2] = 8'h01; seg_n = 3;
    bus_start(); send_seg(); bus_stop();
    check_end("t_post_rst_write");
    chk("lit_post_rst_count_1", 32'(o_wr_count), 32'd1);

    // random transactions
    for (int t = 0; t < 14; t++) begin
      seg_n = $urandom_range(1, 4);
      seg_b[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
      for (int i = 1; i < 8; i++) seg_b[i] = 8'($urandom_range(0, 255));
      bus_start(); send_seg(); bus_stop();
      check_end("t_rand");
    end

    wait_clk(5);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
